dmem_port_arbiter: RTL and testbench

- Shares the single D$/CC request port between the store queue drain (retired stores) and the load FU (cache-bound loads that store-queue forwarding did not fully cover).
- Holds each granted request stable until the cache accepts it.
- Tracks outstanding load responses in order and routes them back with their tags.
- Enforces anti-starvation so retired stores always drain.

---
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_port_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the store-queue, load-FU and D$/CC request/response signals seen by
// dmem_port_arbiter. The arbiter uses the master modport and drives the cache
// port. The environment (SQ, load FU and cache) uses the slave modport.
interface dmem_port_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  // Store queue drain
  logic             st_req;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_size;
  logic             st_accepted;
  // Load FU
  logic             ld_req;
  logic [31:0]      ld_addr;
  logic [1:0]       ld_size;
  logic [TAG_W-1:0] ld_tag;
  logic             ld_accepted;
  logic             ld_resp_valid;
  logic [31:0]      ld_resp_data;
  logic [TAG_W-1:0] ld_resp_tag;
  // D$/CC port
  logic             c_req;
  logic             c_is_store;
  logic [31:0]      c_addr;
  logic [31:0]      c_data;
  logic [1:0]       c_size;
  logic             c_ack;
  logic             c_resp_valid;
  logic [31:0]      c_resp_data;

  modport master (
    input  st_req, st_addr, st_data, st_size,
    output st_accepted,
    input  ld_req, ld_addr, ld_size, ld_tag,
    output ld_accepted, ld_resp_valid, ld_resp_data, ld_resp_tag,
    output c_req, c_is_store, c_addr, c_data, c_size,
    input  c_ack, c_resp_valid, c_resp_data
  );

  modport slave (
    output st_req, st_addr, st_data, st_size,
    input  st_accepted,
    output ld_req, ld_addr, ld_size, ld_tag,
    input  ld_accepted, ld_resp_valid, ld_resp_data, ld_resp_tag,
    input  c_req, c_is_store, c_addr, c_data, c_size,
    output c_ack, c_resp_valid, c_resp_data
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single D$/CC request port between the store-queue drain and the
// load FU. A granted request is held stable until c_ack. Load tags are kept in
// an in-order FIFO so that responses return with their tags. A starve counter
// forces a waiting store through. Flush squashes in-flight load responses.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  dmem_port_arbiter_if.master bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflicts,
  output logic [31:0]         perf_forced_st,
  output logic [31:0]         perf_squashed
`endif
);

  localparam int unsigned PtrW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CntW    = $clog2(MAX_OUT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  // Repeated flushes can stack squashed responses beyond one FIFO's worth.
  localparam int unsigned SquashW = CntW + 4;

  typedef enum logic [1:0] {StIdle, StHoldSt, StHoldLd} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d, data_q, data_d;
  logic [1:0]         size_q, size_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [TAG_W-1:0]   fifo_q [MAX_OUT];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [SquashW-1:0] squash_q, squash_d;

  logic             fifo_full, fifo_empty, forced_st, grant_ld, grant_st;
  logic             push, pop;
  logic [TAG_W-1:0] push_tag;

  // Idle-state arbitration: the load wins unless the FIFO is full, a flush is in
  // progress, or the starved store must go.
  always_comb begin
    fifo_full  = (count_q == CntW'(MAX_OUT));
    fifo_empty = (count_q == '0);
    forced_st  = bus.st_req && (starve_q >= StarveW'(STARVE_LIMIT));
    grant_ld   = (state_q == StIdle) && bus.ld_req && !fifo_full && !forced_st && !flush;
    grant_st   = (state_q == StIdle) && !grant_ld && bus.st_req;
  end

  // Cache port drive: the winner is driven combinationally when idle and from
  // the latch when holding. Everything is gated while reset is high.
  always_comb begin
    bus.c_req      = 1'b0;
    bus.c_is_store = 1'b0;
    bus.c_addr     = '0;
    bus.c_data     = '0;
    bus.c_size     = '0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (grant_ld) begin
            bus.c_req  = 1'b1;
            bus.c_addr = bus.ld_addr;
            bus.c_size = bus.ld_size;
          end else if (grant_st) begin
            bus.c_req      = 1'b1;
            bus.c_is_store = 1'b1;
            bus.c_addr     = bus.st_addr;
            bus.c_data     = bus.st_data;
            bus.c_size     = bus.st_size;
          end
        end
        StHoldSt: begin
          bus.c_req      = 1'b1;
          bus.c_is_store = 1'b1;
          bus.c_addr     = addr_q;
          bus.c_data     = data_q;
          bus.c_size     = size_q;
        end
        StHoldLd: begin
          bus.c_req  = 1'b1;
          bus.c_addr = addr_q;
          bus.c_size = size_q;
        end
        default: ;
      endcase
    end
  end

  // Accept pulses follow directly from the driven request and the cache ack.
  always_comb begin
    bus.st_accepted = bus.c_req && bus.c_is_store && bus.c_ack;
    bus.ld_accepted = bus.c_req && !bus.c_is_store && bus.c_ack;
  end

  // Next state and request latch. A held load is abandoned on flush, but a held
  // store is kept because it is already architectural.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    tag_d   = tag_q;
    case (state_q)
      StIdle: begin
        if ((grant_ld || grant_st) && !bus.c_ack) begin
          state_d = grant_ld ? StHoldLd : StHoldSt;
          addr_d  = bus.c_addr;
          data_d  = bus.c_data;
          size_d  = bus.c_size;
          tag_d   = bus.ld_tag;
        end
      end
      StHoldSt: if (bus.c_ack) state_d = StIdle;
      StHoldLd: if (bus.c_ack || flush) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Starve counter: counts cycles a requesting store is passed over and
  // saturates at STARVE_LIMIT.
  always_comb begin
    if (!bus.st_req || bus.st_accepted) begin
      starve_d = '0;
    end else if (grant_st || state_q == StHoldSt || starve_q >= StarveW'(STARVE_LIMIT)) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // Tag FIFO occupancy and squash accounting. Squashed responses are never
  // pushed into the FIFO, so they do not pop it.
  always_comb begin
    push     = bus.ld_accepted;
    push_tag = (state_q == StHoldLd) ? tag_q : bus.ld_tag;
    pop      = bus.c_resp_valid && (squash_q == '0) && !fifo_empty;
    squash_d = squash_q;
    if (bus.c_resp_valid && squash_q != '0) squash_d = squash_q - SquashW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (flush) begin
      squash_d = squash_d + SquashW'(count_d);
      count_d  = '0;
    end
  end

  // Control state, pointers and the registered response path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= StIdle;
      addr_q            <= '0;
      data_q            <= '0;
      size_q            <= '0;
      tag_q             <= '0;
      starve_q          <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      squash_q          <= '0;
      bus.ld_resp_valid <= 1'b0;
      bus.ld_resp_data  <= '0;
      bus.ld_resp_tag   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      squash_q <= squash_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      bus.ld_resp_valid <= bus.c_resp_valid && (squash_q == '0);
      if (pop) begin
        bus.ld_resp_data <= bus.c_resp_data;
        bus.ld_resp_tag  <= fifo_q[rd_ptr_q];
      end
    end
  end

  // Tag storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= push_tag;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflicts_q, forced_q, squashed_q;

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflicts_q <= '0;
      forced_q    <= '0;
      squashed_q  <= '0;
    end else begin
      if (state_q == StIdle && bus.st_req && bus.ld_req && conflicts_q != '1)
        conflicts_q <= conflicts_q + 32'd1;
      if (grant_st && forced_st && forced_q != '1) forced_q <= forced_q + 32'd1;
      if (bus.c_resp_valid && squash_q != '0 && squashed_q != '1)
        squashed_q <= squashed_q + 32'd1;
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_forced_st = forced_q;
  assign perf_squashed  = squashed_q;
`endif

  // A response with nothing outstanding means the cache and arbiter disagree.
  a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
    !(bus.c_resp_valid && fifo_empty && squash_q == '0));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: store/load grants, hold stability,
// starvation, FIFO-full blocking, flush squashing and reset during a hold.
module tb_dmem_port_arbiter;
  logic clock;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  dmem_port_arbiter_if #(.TAG_W(4)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_forced_st, perf_squashed;
`endif

  dmem_port_arbiter #(
    .TAG_W       (4),
    .MAX_OUT     (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_conflicts(perf_conflicts),
    .perf_forced_st(perf_forced_st),
    .perf_squashed (perf_squashed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush            = 1'b0;
    bus.st_req       = 1'b0;
    bus.st_addr      = '0;
    bus.st_data      = '0;
    bus.st_size      = '0;
    bus.ld_req       = 1'b0;
    bus.ld_addr      = '0;
    bus.ld_size      = '0;
    bus.ld_tag       = '0;
    bus.c_ack        = 1'b0;
    bus.c_resp_valid = 1'b0;
    bus.c_resp_data  = '0;
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) next_cycle();
    reset = 1'b0;
    #1;
    chk1("rst_c_req", bus.c_req, 1'b0);
    chk1("rst_st_acc", bus.st_accepted, 1'b0);
    chk1("rst_ld_acc", bus.ld_accepted, 1'b0);
    chk1("rst_resp_valid", bus.ld_resp_valid, 1'b0);
    chk32("rst_resp_data", bus.ld_resp_data, 32'h0);
    chk32("rst_resp_tag", 32'(bus.ld_resp_tag), 32'h0);

    // Store only, acked in the grant cycle
    next_cycle();
    bus.st_req = 1'b1; bus.st_addr = 32'h100; bus.st_data = 32'hDEADBEEF; bus.st_size = 2'd2;
    bus.c_ack = 1'b1;
    #1;
    chk1("st_c_req", bus.c_req, 1'b1);
    chk1("st_c_is_store", bus.c_is_store, 1'b1);
    chk32("st_c_addr", bus.c_addr, 32'h100);
    chk32("st_c_data", bus.c_data, 32'hDEADBEEF);
    chk32("st_c_size", 32'(bus.c_size), 32'd2);
    chk1("st_accepted", bus.st_accepted, 1'b1);
    chk1("st_no_ld_acc", bus.ld_accepted, 1'b0);
    next_cycle();
    clear_inputs();
    #1;
    chk1("st_back_idle", bus.c_req, 1'b0);

    // Load with 3 cycles of delayed ack; the latched request must not follow inputs
    next_cycle();
    bus.ld_req = 1'b1; bus.ld_tag = 4'd5; bus.ld_addr = 32'h200; bus.ld_size = 2'd2;
    #1;
    chk1("ld0_c_req", bus.c_req, 1'b1);
    chk1("ld0_is_store", bus.c_is_store, 1'b0);
    chk32("ld0_c_addr", bus.c_addr, 32'h200);
    chk32("ld0_c_data", bus.c_data, 32'h0);
    chk1("ld0_no_acc", bus.ld_accepted, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      bus.ld_req = 1'b0; bus.ld_addr = 32'h999; bus.ld_tag = 4'd0; bus.ld_size = 2'd0;
      #1;
      chk1("ld_hold_c_req", bus.c_req, 1'b1);
      chk32("ld_hold_addr", bus.c_addr, 32'h200);
      chk32("ld_hold_size", 32'(bus.c_size), 32'd2);
      chk1("ld_hold_no_acc", bus.ld_accepted, 1'b0);
    end
    next_cycle();
    bus.c_ack = 1'b1;
    #1;
    chk32("ld3_addr", bus.c_addr, 32'h200);
    chk1("ld3_acc", bus.ld_accepted, 1'b1);
    next_cycle();
    bus.c_ack = 1'b0;
    #1;
    chk1("ld4_idle", bus.c_req, 1'b0);
    next_cycle();
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'h12345678;
    #1;
    chk1("ld_resp_not_yet", bus.ld_resp_valid, 1'b0);
    next_cycle();
    bus.c_resp_valid = 1'b0; bus.c_resp_data = 32'h0;
    #1;
    chk1("ld_resp_valid", bus.ld_resp_valid, 1'b1);
    chk32("ld_resp_tag", 32'(bus.ld_resp_tag), 32'd5);
    chk32("ld_resp_data", bus.ld_resp_data, 32'h12345678);
    next_cycle();
    #1;
    chk1("ld_resp_pulse", bus.ld_resp_valid, 1'b0);

    // Starvation: loads win cycles 0..7, store forced at cycle 8, then load again
    for (int k = 0; k <= 9; k++) begin
      next_cycle();
      bus.st_req = 1'b1; bus.st_addr = 32'h300; bus.st_data = 32'h55; bus.st_size = 2'd2;
      bus.ld_req = 1'b1; bus.ld_addr = 32'h340; bus.ld_tag = 4'(k); bus.ld_size = 2'd2;
      bus.c_ack = 1'b1;
      bus.c_resp_valid = (k >= 1 && k <= 8);
      bus.c_resp_data = 32'(k);
      #1;
      if (k < 8 || k == 9) begin
        chk1("starve_ld_acc", bus.ld_accepted, 1'b1);
        chk1("starve_st_wait", bus.st_accepted, 1'b0);
      end else begin
        chk1("starve_st_forced", bus.st_accepted, 1'b1);
        chk1("starve_ld_lose", bus.ld_accepted, 1'b0);
        chk1("starve_is_store", bus.c_is_store, 1'b1);
      end
      if (k >= 2) begin
        chk1("starve_resp_v", bus.ld_resp_valid, 1'b1);
        chk32("starve_resp_tag", 32'(bus.ld_resp_tag), 32'(k - 2));
        chk32("starve_resp_data", bus.ld_resp_data, 32'(k - 1));
      end
    end
    next_cycle();
    clear_inputs();
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'h99;
    next_cycle();
    clear_inputs();
    #1;
    chk1("starve_last_resp_v", bus.ld_resp_valid, 1'b1);
    chk32("starve_last_tag", 32'(bus.ld_resp_tag), 32'd9);

    // FIFO full: four loads outstanding block a fifth; a pending store goes instead
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      clear_inputs();
      bus.ld_req = 1'b1; bus.ld_tag = 4'(k); bus.ld_addr = 32'h400; bus.c_ack = 1'b1;
      #1;
      chk1("fill_ld_acc", bus.ld_accepted, 1'b1);
    end
    next_cycle();
    bus.ld_tag = 4'd6;
    bus.st_req = 1'b1; bus.st_addr = 32'h480; bus.st_data = 32'h77; bus.st_size = 2'd0;
    #1;
    chk1("full_ld_blocked", bus.ld_accepted, 1'b0);
    chk1("full_st_granted", bus.st_accepted, 1'b1);
    chk1("full_is_store", bus.c_is_store, 1'b1);
    next_cycle();
    bus.st_req = 1'b0;
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'h11;
    #1;
    chk1("full_pop_cycle_blocked", bus.ld_accepted, 1'b0);
    next_cycle();
    bus.c_resp_valid = 1'b0;
    #1;
    chk1("full_ld_resumes", bus.ld_accepted, 1'b1);
    chk1("full_resp_v", bus.ld_resp_valid, 1'b1);
    chk32("full_resp_tag", 32'(bus.ld_resp_tag), 32'd1);
    chk32("full_resp_data", bus.ld_resp_data, 32'h11);

    // Flush: 3 in flight (tags 3,4,6) plus an unacked held load
    next_cycle();
    clear_inputs();
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'h22;
    next_cycle();
    clear_inputs();
    bus.ld_req = 1'b1; bus.ld_tag = 4'd7; bus.ld_addr = 32'h500;
    #1;
    chk1("fl_hold_c_req", bus.c_req, 1'b1);
    chk32("fl_prev_resp_tag", 32'(bus.ld_resp_tag), 32'd2);
    next_cycle();
    bus.ld_req = 1'b0;
    flush = 1'b1;
    #1;
    chk1("fl_no_acc", bus.ld_accepted, 1'b0);
    next_cycle();
    flush = 1'b0;
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'h33;
    #1;
    chk1("fl_hold_dropped", bus.c_req, 1'b0);
    next_cycle();
    #1;
    chk1("fl_squash1", bus.ld_resp_valid, 1'b0);
    next_cycle();
    bus.ld_req = 1'b1; bus.ld_tag = 4'd9; bus.ld_addr = 32'h540; bus.c_ack = 1'b1;
    #1;
    chk1("fl_squash2", bus.ld_resp_valid, 1'b0);
    chk1("fl_new_ld_acc", bus.ld_accepted, 1'b1);
    next_cycle();
    clear_inputs();
    bus.c_resp_valid = 1'b1; bus.c_resp_data = 32'hABCD;
    #1;
    chk1("fl_squash3", bus.ld_resp_valid, 1'b0);
    next_cycle();
    clear_inputs();
    #1;
    chk1("fl_new_resp_v", bus.ld_resp_valid, 1'b1);
    chk32("fl_new_resp_tag", 32'(bus.ld_resp_tag), 32'd9);
    chk32("fl_new_resp_data", bus.ld_resp_data, 32'hABCD);

    // Flush in idle: load grant suppressed, store still granted
    next_cycle();
    flush = 1'b1;
    bus.ld_req = 1'b1; bus.ld_tag = 4'd1; bus.ld_addr = 32'h580;
    bus.st_req = 1'b1; bus.st_addr = 32'h5C0; bus.st_data = 32'h88; bus.st_size = 2'd2;
    bus.c_ack = 1'b1;
    #1;
    chk1("fl_idle_ld_supp", bus.ld_accepted, 1'b0);
    chk1("fl_idle_st_acc", bus.st_accepted, 1'b1);
    chk32("fl_idle_st_addr", bus.c_addr, 32'h5C0);

    // Flush during a held store: request is kept and completes on the later ack
    next_cycle();
    clear_inputs();
    bus.st_req = 1'b1; bus.st_addr = 32'h600; bus.st_data = 32'hCAFE; bus.st_size = 2'd1;
    #1;
    chk1("hst_c_req", bus.c_req, 1'b1);
    next_cycle();
    flush = 1'b1;
    bus.st_addr = 32'h777;
    #1;
    chk32("hst_flush_addr", bus.c_addr, 32'h600);
    chk1("hst_flush_no_acc", bus.st_accepted, 1'b0);
    next_cycle();
    flush = 1'b0;
    bus.c_ack = 1'b1;
    #1;
    chk32("hst_ack_addr", bus.c_addr, 32'h600);
    chk32("hst_ack_data", bus.c_data, 32'hCAFE);
    chk32("hst_ack_size", 32'(bus.c_size), 32'd1);
    chk1("hst_ack_acc", bus.st_accepted, 1'b1);
    next_cycle();
    clear_inputs();
    #1;
    chk1("hst_idle", bus.c_req, 1'b0);

    // Reset while holding a load drops it with no accept pulse
    next_cycle();
    bus.ld_req = 1'b1; bus.ld_tag = 4'd3; bus.ld_addr = 32'h800;
    next_cycle();
    bus.ld_req = 1'b0;
    reset = 1'b1;
    bus.c_ack = 1'b1;
    #1;
    chk1("rsthold_c_req", bus.c_req, 1'b0);
    chk1("rsthold_no_acc", bus.ld_accepted, 1'b0);
    next_cycle();
    reset = 1'b0;
    bus.c_ack = 1'b0;
    #1;
    chk1("rsthold_idle", bus.c_req, 1'b0);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
